iob_fp_accum: RTL

//  Streaming FP sum-reduction controller placed directly upstream of the pipelined FP adder (iob_fp_add).

---
 rtl/iob_fp_accum.sv | 85 ++++++++
 1 files changed

// File: rtl/iob_fp_accum.sv
// iob_fp_accum: streaming FP sum-reduction controller feeding a pipelined FP adder.
// Optional element counter port cnt_o is enabled by defining FP_ACC_COUNT_EN.
module iob_fp_accum #(
  parameter int DATA_W  = 32,
  parameter int EXP_W   = 8,
  parameter int ADD_LAT = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              add_start_o,
  output logic [DATA_W-1:0] add_a_o,
  output logic [DATA_W-1:0] add_b_o,
  input  logic              add_done_i,
  input  logic [DATA_W-1:0] add_res_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_o
`ifdef FP_ACC_COUNT_EN
  ,output logic [15:0]      cnt_o
`endif
);
  localparam int CW = $clog2(ADD_LAT + 2);

  if (EXP_W < 2 || EXP_W > DATA_W - 2) begin : g_bad_exp
    $error("iob_fp_accum: EXP_W out of range for DATA_W");
  end

  typedef enum logic [1:0] {ACC, DRN, OUT} state_t;

  state_t            state;
  logic [DATA_W-1:0] h;
  logic              hv;
  logic [CW-1:0]     inflight;
  logic              x, y, one, issue;

  assign in_ready_o = state == ACC;
  assign x          = in_valid_i & in_ready_o;
  assign y          = add_done_i;
  assign one        = x ^ y;
  // A fresh pair (X,Y) bypasses the hold register; a lone operand pairs with H if present.
  assign issue      = (x & y) | (one & hv);

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state       <= ACC;
      h           <= '0;
      hv          <= 1'b0;
      inflight    <= '0;
      add_start_o <= 1'b0;
      add_a_o     <= '0;
      add_b_o     <= '0;
      res_valid_o <= 1'b0;
      res_o       <= '0;
    end else begin
      add_start_o <= issue;
      add_a_o     <= issue ? (x & y ? in_data_i : h) : '0;
      add_b_o     <= issue ? (y ? add_res_i : in_data_i) : '0;
      if (one) hv <= ~hv;
      if (one && !hv) h <= x ? in_data_i : add_res_i;
      inflight    <= inflight + CW'(issue) - CW'(y);
      if (state == ACC && x && in_last_i) state <= DRN;
      if (state == DRN && inflight == '0 && !y && hv) begin
        state       <= OUT;
        res_o       <= h;
        res_valid_o <= 1'b1;
      end
      if (state == OUT && res_ready_i) begin
        state       <= ACC;
        hv          <= 1'b0;
        res_valid_o <= 1'b0;
        res_o       <= '0;
      end
    end

`ifdef FP_ACC_COUNT_EN
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt_o <= '0;
    else if (state == OUT && res_ready_i) cnt_o <= '0;
    else if (x && cnt_o != 16'hFFFF) cnt_o <= cnt_o + 16'd1;
`endif
endmodule
